// File: rtl/oldland_mem_responder.sv
// ---------------------------------------------------------------------------
// oldland_mem_responder
//
// Target end of the oldland word-addressed memory bus. Acts as on-chip
// RAM / boot ROM behind the bus arbiter and is the reference target used
// when exercising cache line fills and cache bypass.
//
// A request is accepted in IDLE, optionally held for WAIT_CYCLES cycles in
// WAIT, and completed with a single-cycle ACK. Reads return a whole 32-bit
// word. Writes update only the byte lanes selected by m_bytesel. Accesses
// outside the address window, and any write when READ_ONLY is set, complete
// with m_error and leave the array untouched.
//
// Parameters:
//   ADDR_BITS   log2 of array depth in 32-bit words (must be < 30)
//   BASE_ADDR   word address of the window base; low ADDR_BITS bits ignored
//   WAIT_CYCLES extra cycles between acceptance and ack (0 allowed)
//   READ_ONLY   1 = every write completes with error and no update
//
// Ports:
//   clk        clock, all logic on the rising edge
//   rst        synchronous active-low reset
//   m_access   request valid, held by the initiator until the ack cycle
//   m_addr     30-bit word address
//   m_wr_val   write data
//   m_wr_en    1 = write, 0 = read
//   m_bytesel  byte lane enables, bit n covers data[8n+7:8n]
//   m_data     read data, valid only in the ack cycle, otherwise 0
//   m_ack      one-cycle completion pulse
//   m_error    asserted together with m_ack on a failed access
//
// Latency: request first seen in IDLE at cycle N acks at N+1+WAIT_CYCLES.
// The array contents are not affected by reset.
// ---------------------------------------------------------------------------
module oldland_mem_responder #(
  parameter int unsigned ADDR_BITS   = 12,
  parameter logic [29:0] BASE_ADDR   = 30'h0,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter bit          READ_ONLY   = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m_access,
  input  logic [29:0] m_addr,
  input  logic [31:0] m_wr_val,
  input  logic        m_wr_en,
  input  logic [3:0]  m_bytesel,
  output logic [31:0] m_data,
  output logic        m_ack,
  output logic        m_error
);

  localparam int unsigned DEPTH = 1 << ADDR_BITS;
  // Counter only has to hold WAIT_CYCLES down to 1.
  localparam int unsigned CNT_W = (WAIT_CYCLES < 2) ? 1 : $clog2(WAIT_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  genvar gi;

  state_t               state_reg, state_next;
  logic [CNT_W-1:0]     cnt_reg, cnt_next;

  // Latched request. Only the array index and the window decode result are
  // kept from the address; that is all the rest of the transaction needs.
  logic [ADDR_BITS-1:0] idx_reg;
  logic                 hit_reg;
  logic [31:0]          wr_val_reg;
  logic                 wr_en_reg;
  logic [3:0]           bytesel_reg;

  // Registered bus outputs.
  logic                 ack_reg;
  logic                 err_reg;
  logic                 rd_en_reg;
  logic [31:0]          rd_data_reg;

  logic [31:0]          mem_array [DEPTH];

  logic                 accept;
  logic                 addr_hit;
  logic                 enter_ack;
  logic [ADDR_BITS-1:0] cur_idx;
  logic                 cur_hit;
  logic                 cur_wr;
  logic                 cur_rd_ok;
  logic                 cur_err;
  logic                 wr_commit;
  logic [3:0]           lane_we;

  // -------------------------------------------------------------------------
  // Request acceptance and window decode
  // -------------------------------------------------------------------------
  assign accept   = (state_reg == ST_IDLE) && m_access;
  assign addr_hit = (m_addr[29:ADDR_BITS] == BASE_ADDR[29:ADDR_BITS]);

  // The transaction being moved into ACK comes straight from the bus when
  // leaving IDLE (WAIT_CYCLES = 0) and from the latched copy when leaving
  // WAIT. Muxing on the current state covers both cases.
  always_comb begin
    cur_idx = idx_reg;
    cur_hit = hit_reg;
    cur_wr  = wr_en_reg;
    if (state_reg == ST_IDLE) begin
      cur_idx = m_addr[ADDR_BITS-1:0];
      cur_hit = addr_hit;
      cur_wr  = m_wr_en;
    end
  end

  assign cur_rd_ok = cur_hit && !cur_wr;
  assign cur_err   = !cur_hit || (cur_wr && READ_ONLY);

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next state
  // -------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      ST_IDLE: begin
        if (m_access) begin
          if (WAIT_CYCLES == 0) begin
            state_next = ST_ACK;
          end else begin
            state_next = ST_WAIT;
            cnt_next   = CNT_W'(WAIT_CYCLES);
          end
        end
      end
      ST_WAIT: begin
        // A dropped request wins over a pending ack: the initiator has
        // abandoned the transfer, so nothing is acked or written.
        if (!m_access) begin
          state_next = ST_IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
          if (cnt_reg == CNT_W'(1)) begin
            state_next = ST_ACK;
          end
        end
      end
      ST_ACK: begin
        // m_access is ignored here; a request still held next cycle is a
        // fresh transaction, which is what back-to-back line fills rely on.
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  assign enter_ack = (state_next == ST_ACK);

  // -------------------------------------------------------------------------
  // Request latch and registered bus outputs
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      idx_reg     <= '0;
      hit_reg     <= 1'b0;
      wr_val_reg  <= '0;
      wr_en_reg   <= 1'b0;
      bytesel_reg <= '0;
      ack_reg     <= 1'b0;
      err_reg     <= 1'b0;
      rd_en_reg   <= 1'b0;
    end else begin
      if (accept) begin
        idx_reg     <= m_addr[ADDR_BITS-1:0];
        hit_reg     <= addr_hit;
        wr_val_reg  <= m_wr_val;
        wr_en_reg   <= m_wr_en;
        bytesel_reg <= m_bytesel;
      end
      ack_reg   <= enter_ack;
      err_reg   <= enter_ack && cur_err;
      rd_en_reg <= enter_ack && cur_rd_ok;
    end
  end

  // -------------------------------------------------------------------------
  // Word array with per-lane write enables and registered read
  // -------------------------------------------------------------------------
  // The write lands at the end of the ACK cycle. Gating with rst keeps a
  // reset that coincides with ACK from committing the write.
  assign wr_commit = (state_reg == ST_ACK) && rst && hit_reg && wr_en_reg && !READ_ONLY;

  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane_we
      assign lane_we[gi] = wr_commit && bytesel_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (lane_we[i]) begin
        mem_array[idx_reg][8*i +: 8] <= wr_val_reg[8*i +: 8];
      end
    end
    // Read is issued on the edge that enters ACK so the word is ready in
    // the ACK cycle without any path from bus inputs to bus outputs.
    if (enter_ack && cur_rd_ok) begin
      rd_data_reg <= mem_array[cur_idx];
    end
  end

  // rd_data_reg is not reset (block RAM output register); the registered
  // enable keeps the bus at 0 outside a successful read ack so it can be
  // OR-combined with other targets.
  assign m_data  = rd_en_reg ? rd_data_reg : 32'h0;
  assign m_ack   = ack_reg;
  assign m_error = err_reg;

endmodule

// File: doc/oldland_mem_responder.md
Name: oldland_mem_responder

Overview:
- Responder (target) end of the oldland word-addressed memory bus: the bus that cache ways and cache bypass drive as initiators.
- Services single-word reads and byte-masked writes into an internal synchronous word array within one address window.
- Inserts a configurable number of wait states.
- Signals an error for out-of-window accesses and for writes when read-only.
- Sits behind the bus arbiter as on-chip RAM/boot ROM and is the reference target for cache fill and bypass testing.

Parameters:
ADDR_BITS, 12, log2 of array depth in 32-bit words (4096 words = 16 KiB).
BASE_ADDR, 30'h0, word address of window base; bits [ADDR_BITS-1:0] ignored.
WAIT_CYCLES, 2, extra cycles between acceptance and ack (0 allowed).
READ_ONLY, 1'b0, 1 = every write completes with error and no update.

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous active-low reset
m_access  input  1  request valid, held by initiator until the ack cycle
m_addr  input  30  word address
m_wr_val  input  32  write data
m_wr_en  input  1  1 = write, 0 = read
m_bytesel  input  4  byte lane enables, bit n = data[8n+7:8n]
m_data  output  32  read data, valid only in ack cycle, else 0
m_ack  output  1  one-cycle completion pulse
m_error  output  1  asserted with m_ack on a failed access

Behaviour:
Reset (rst low at a clock edge):
- State goes to IDLE.
- m_ack, m_error and m_data are 0 from the next cycle.
- Wait counter and latched request are cleared.
- Array contents are not cleared.
- Reset mid-transaction aborts the transaction with no ack and no write.

State IDLE:
- If m_access is 1, latch addr, wr_val, wr_en and bytesel and compute decode.
- Decode hit = (m_addr[29:ADDR_BITS] == BASE_ADDR[29:ADDR_BITS]).
- Go to WAIT, loading the counter with WAIT_CYCLES.
- With WAIT_CYCLES = 0, go directly to ACK.

State WAIT:
- Counter decrements each cycle.
- Go to ACK on the cycle the counter reaches 1.
- If m_access drops to 0, abort to IDLE: no ack, no write.
- Bus inputs are ignored after latching; the initiator must hold them but changes have no effect.

State ACK (exactly one cycle):
- m_ack = 1.
- Good read (hit): m_data = array word at latched addr[ADDR_BITS-1:0], all 32 bits regardless of bytesel.
- Good write (hit and READ_ONLY = 0): at the end of the ACK cycle, update only lanes with bytesel = 1; m_data = 0.
- Error (miss, or write while READ_ONLY = 1): m_error = 1, m_data = 0, no array update.
- Always returns to IDLE.
- m_access in the ACK cycle is ignored.
- A request still or newly asserted in the following IDLE cycle is treated as a new transaction. This supports back-to-back line-fill words.

Latency:
- m_access first seen high in IDLE at cycle N gives m_ack at cycle N+1+WAIT_CYCLES.
- Throughput is one word per 2+WAIT_CYCLES cycles.

Bus outputs:
- m_data, m_ack and m_error are registered and are 0 outside the ACK cycle. The bus is OR-combined across targets.
- Array read is registered and issued on the cycle entering ACK, so there is no combinational path from inputs to outputs.

Other rules:
- bytesel = 4'b0000 on a write is a successful no-op write with ack and no error.
- Read-after-write to the same address in the next transaction returns the new data.
- Array address index is latched addr[ADDR_BITS-1:0]; there is no wrap into a neighbouring window.

Test Plan:
- Reset, then read: rst low 2 cycles, array[5] preloaded 32'hDEADBEEF, WAIT_CYCLES = 2, read addr BASE+5 at cycle N -> outputs 0 during reset; m_ack = 1 and m_data = 32'hDEADBEEF only at N+3; m_error = 0.
- Byte-masked write then read: word 7 = 32'h11223344, write 32'hAABBCCDD with bytesel = 4'b0101, then read word 7 -> write acks without error; read returns 32'h11BB33DD.
- Back-to-back line fill: m_access held high, address advanced after each ack over 8 words (WAIT_CYCLES = 0) -> 8 acks spaced exactly 2 cycles apart with correct data; m_data = 0 between acks.
- Errors: read at BASE + 2^ADDR_BITS -> m_ack = 1, m_error = 1, m_data = 0. With READ_ONLY = 1, write to BASE+3 -> ack with error; a following read of word 3 returns its old value.
- Abort: m_access dropped during the second WAIT cycle of a write (WAIT_CYCLES = 3) -> no ack, array unchanged; the next request is serviced normally.
- Reset mid-transaction: rst asserted during WAIT of a write -> no ack, array unchanged, IDLE after reset; a new read completes with standard latency.
